// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax normaliser: exp word layout,
// linear expansion of an exp word, and the normaliser FSM states.
package softmax_pkg;

    localparam int EXP_W  = 21;
    localparam int POS_W  = 5;
    localparam int MANT_W = 16;
    localparam int LIN_W  = 47;

    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [MANT_W-1:0] mant;
    } exp_word_t;

    typedef enum logic [1:0] {
        ACCUM,
        LOAD,
        ITER,
        OUT
    } state_t;

    function automatic logic [LIN_W-1:0] exp_to_lin(input exp_word_t w);
        return LIN_W'(w.mant) << w.pos;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring bit-serial divider producing a Q0.OUT_W fraction dividend/divisor.
// Zero divisor and dividend==divisor finish combinationally in the start cycle.
module seq_divider
    import softmax_pkg::*;
#(
    parameter int SUM_W = 50,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LIN_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic             done,
    output logic [OUT_W-1:0] quotient
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    logic [SUM_W:0]   rem_q, rem_d, shifted, trial;
    logic [OUT_W-1:0] quo_q, quo_d, quo_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, fits;

    always_comb begin
        shifted  = rem_q << 1;
        fits     = shifted >= {1'b0, divisor};
        trial    = shifted - {1'b0, divisor};
        quo_next = OUT_W'({quo_q, fits});

        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;
        quotient = quo_next;

        if (start) begin
            rem_d  = (SUM_W + 1)'(dividend);
            quo_d  = '0;
            cnt_d  = CNT_W'(OUT_W);
            busy_d = 1'b1;
            if (divisor == '0) begin
                busy_d   = 1'b0;
                done     = 1'b1;
                quotient = '0;
            end else if (SUM_W'(dividend) == divisor) begin
                // The only way the fraction reaches 1.0 is the element being the whole sum
                busy_d   = 1'b0;
                done     = 1'b1;
                quotient = '1;
            end
        end else if (busy_q) begin
            rem_d = fits ? trial : shifted;
            quo_d = quo_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers a vector of exp words, sums their linear values,
// then streams out each element's probability exp_i / sum as a Q0.OUT_W fraction.
module softmax_norm
    import softmax_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_prob,
    output logic             out_last,
    output logic             out_zero_sum
);

    localparam int IDX_W = $clog2(VEC_LEN);
    localparam int SUM_W = LIN_W + IDX_W;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    exp_word_t        buffer_q [VEC_LEN];
    exp_word_t        buffer_d [VEC_LEN];
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_prob_q, out_prob_d;
    logic             out_last_q, out_last_d;
    logic             out_zero_sum_q, out_zero_sum_d;

    logic             accept, idx_last, div_start, div_done;
    logic [OUT_W-1:0] div_quot;
    logic [LIN_W-1:0] cur_lin;

    assign accept   = in_valid && in_ready_q;
    assign idx_last = (idx_q == IDX_W'(VEC_LEN - 1));
    assign cur_lin  = exp_to_lin(buffer_q[idx_q]);

    seq_divider #(
        .SUM_W(SUM_W),
        .OUT_W(OUT_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(cur_lin),
        .divisor (sum_q),
        .done    (div_done),
        .quotient(div_quot)
    );

    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        idx_d          = idx_q;
        buffer_d       = buffer_q;
        in_ready_d     = in_ready_q;
        out_valid_d    = out_valid_q;
        out_prob_d     = out_prob_q;
        out_last_d     = out_last_q;
        out_zero_sum_d = out_zero_sum_q;
        div_start      = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    buffer_d[idx_q] = exp_word_t'(in_exp);
                    sum_d           = sum_q + SUM_W'(exp_to_lin(exp_word_t'(in_exp)));
                    if (idx_last) begin
                        idx_d      = '0;
                        state_d    = LOAD;
                        in_ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                div_start = 1'b1;
                state_d   = ITER;
            end
            ITER: begin
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        sum_d      = '0;
                        idx_d      = '0;
                        state_d    = ACCUM;
                        in_ready_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase

        // Forced results finish during LOAD itself, normal ones at the last ITER cycle
        if (div_done) begin
            state_d        = OUT;
            out_valid_d    = 1'b1;
            out_prob_d     = div_quot;
            out_last_d     = idx_last;
            out_zero_sum_d = (sum_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            sum_q          <= '0;
            idx_q          <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_prob_q     <= '0;
            out_last_q     <= 1'b0;
            out_zero_sum_q <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                buffer_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            idx_q          <= idx_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_prob_q     <= out_prob_d;
            out_last_q     <= out_last_d;
            out_zero_sum_q <= out_zero_sum_d;
            buffer_q       <= buffer_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_prob     = out_prob_q;
    assign out_last     = out_last_q;
    assign out_zero_sum = out_zero_sum_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Randomised bench for softmax_norm: directed and random vectors checked
// against an arithmetic model of exp_i * 2^16 / sum.
module tb_softmax_norm;

    localparam int VEC_LEN = 8;
    localparam int OUT_W   = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prob;
    logic        out_last;
    logic        out_zero_sum;

    int assertions = 0;
    int failures   = 0;
    int cycle      = 0;
    int refCycle   = 0;

    logic [20:0]     vec [VEC_LEN];
    longint unsigned lin [VEC_LEN];
    longint unsigned sum;

    softmax_norm #(
        .VEC_LEN(VEC_LEN),
        .OUT_W  (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_prob    (out_prob),
        .out_last    (out_last),
        .out_zero_sum(out_zero_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        assertions++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, expv, cycle);
        end
    endtask

    // Reference model: linear values and sum straight from the word format
    task automatic buildModel();
        sum = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            lin[i] = longint'(vec[i][15:0]) << vec[i][20:16];
            sum += lin[i];
        end
    endtask

    function automatic logic [15:0] expectedProb(input int i);
        longint unsigned q;
        if (sum == 0) return 16'h0000;
        q = (lin[i] << 16) / sum;
        if (q > 64'hFFFF) q = 64'hFFFF;
        return q[15:0];
    endfunction

    function automatic int expectedLatency(input int i);
        if (sum == 0 || lin[i] == sum) return 2;
        return OUT_W + 2;
    endfunction

    task automatic applyStimulus();
        int waited;
        buildModel();
        for (int i = 0; i < VEC_LEN; i++) begin
            in_exp   = vec[i];
            in_valid = 1'b1;
            waited   = 0;
            while (!in_ready && waited < 50) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_wait", 0, 1);
                in_valid = 1'b0;
                return;
            end
            refCycle = cycle;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("in_ready_drop", in_ready, 0);
    endtask

    task automatic collectOutputs(input int stall, input int count);
        int waited;
        for (int i = 0; i < count; i++) begin
            waited = 0;
            while (!out_valid && waited < 100) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (!out_valid) begin
                checkOutput("out_valid_wait", 0, 1);
                return;
            end
            checkOutput("latency", cycle - refCycle, expectedLatency(i));
            checkOutput("prob", out_prob, expectedProb(i));
            checkOutput("last", out_last, (i == VEC_LEN - 1));
            checkOutput("zero_sum", out_zero_sum, (sum == 0));
            checkOutput("in_ready_busy", in_ready, 0);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_prob", out_prob, expectedProb(i));
                checkOutput("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            refCycle  = cycle;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput("valid_drop", out_valid, 0);
            if (i == VEC_LEN - 1) checkOutput("in_ready_back", in_ready, 1);
        end
    endtask

    task automatic fillUniform();
        for (int i = 0; i < VEC_LEN; i++) vec[i] = {5'd16, 16'h8000};
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        out_ready = 1'b0;

        #12;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_prob", out_prob, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_zero_sum", out_zero_sum, 0);
        #10;
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_pre", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_rise", in_ready, 1);

        $display("[TB] uniform vector");
        fillUniform();
        applyStimulus();
        collectOutputs(0, VEC_LEN);

        $display("[TB] ratio vector");
        for (int i = 0; i < VEC_LEN; i++) vec[i] = {5'd16, 16'h0000};
        vec[0] = {5'd16, 16'h8000};
        vec[1] = {5'd17, 16'h8000};
        applyStimulus();
        collectOutputs(0, VEC_LEN);

        $display("[TB] one-hot saturation");
        for (int i = 0; i < VEC_LEN; i++) vec[i] = {5'd3, 16'h0000};
        vec[0] = {5'd20, 16'hFFFF};
        applyStimulus();
        collectOutputs(0, VEC_LEN);

        $display("[TB] zero sum");
        for (int i = 0; i < VEC_LEN; i++) vec[i] = {5'(i), 16'h0000};
        applyStimulus();
        collectOutputs(0, VEC_LEN);

        $display("[TB] backpressure");
        fillUniform();
        applyStimulus();
        collectOutputs(5, VEC_LEN);

        $display("[TB] reset mid-operation");
        fillUniform();
        applyStimulus();
        collectOutputs(0, 3);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("pre_rst_prob", out_prob, 16'h2000);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_prob", out_prob, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);
        fillUniform();
        applyStimulus();
        collectOutputs(0, VEC_LEN);

        $display("[TB] random vectors");
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                vec[i][20:16] = (v % 2 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(10, 13));
                vec[i][15:0]  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
            end
            applyStimulus();
            collectOutputs($urandom_range(0, 2), VEC_LEN);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Downstream normaliser of the softmax datapath; consumes the 21-bit approximate exponentials produced by the per-element exp stage.
- Collects a vector of VEC_LEN exp values, accumulates their linear sum, then emits each element's probability exp_i / sum as an unsigned Q0.16 fraction.
- Division is bit-serial restoring: one quotient bit per cycle.

Parameters:
- VEC_LEN, 8: elements per softmax vector; power of two, ≥2.
- OUT_W, 16: probability fraction bits (Q0.OUT_W).

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: exp word valid.
- in_ready, output, 1: block accepts an exp word.
- in_exp, input, 21: {pos[20:16], mant[15:0]}; linear value = mant << pos.
- out_valid, output, 1: probability valid.
- out_ready, input, 1: downstream accepts.
- out_prob, output, OUT_W: floor(lin_i·2^OUT_W / sum), saturated to all-ones.
- out_last, output, 1: high with the final element of the vector.
- out_zero_sum, output, 1: high on every output of a vector whose sum is 0.

Behaviour:
- Reset (any time, including mid-vector or mid-divide) aborts the vector. Outputs go to: in_ready=0, out_valid=0, out_prob=0, out_last=0, out_zero_sum=0. State goes to ACCUM, sum=0, index=0.
- in_ready rises on the first clock edge after reset release.
- Width rules:
  - lin = mant << pos, LIN_W = 47 bits.
  - sum width SUM_W = LIN_W + clog2(VEC_LEN) = 50; sum cannot overflow.
  - Divider remainder is SUM_W+1 bits.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: store raw 21-bit word in buffer[idx], add lin to sum, idx++.
  - On the VEC_LEN-th accept: next state LOAD, idx=0, in_ready=0 in the following cycle.
  - Input is never accepted outside ACCUM.
- LOAD (1 cycle):
  - rem = lin(buffer[idx]), q = 0, bit counter = OUT_W.
  - If sum==0, or lin==sum: result is forced (0 or all-ones respectively), skip to OUT.
  - Otherwise go to ITER.
- ITER (OUT_W cycles): rem = rem<<1; if rem ≥ sum then rem -= sum and shift in 1, else shift in 0. After the last bit go to OUT.
- OUT:
  - out_valid=1; out_prob, out_last (idx==VEC_LEN-1) and out_zero_sum are registered and held stable until out_ready.
  - On handshake: if last, clear sum and go to ACCUM; else idx++ and go to LOAD.
  - out_valid deasserts the cycle after the handshake.
- Timing:
  - Per-element latency LOAD→out_valid = OUT_W+1 cycles; forced cases take 1 cycle.
  - First out_valid occurs OUT_W+2 cycles after the last input accept.
- Backpressure: out_ready low holds all outputs and state indefinitely, with no loss.
- Consecutive vectors are not overlapped. in_ready=1 is first seen the cycle after the final output handshake.
- Buffer: VEC_LEN×21 flops; raw words are re-expanded to lin in LOAD via the shared shift function.

Decomposition:
- Package softmax_pkg holds:
  - constants EXP_W=21, POS_W=5, MANT_W=16, LIN_W=47;
  - typedef exp_word_t (packed struct pos/mant);
  - function exp_to_lin;
  - enum state_t {ACCUM, LOAD, ITER, OUT}.
- One sub-module, seq_divider: restoring bit-serial divider with start/done.
  - Ports: dividend LIN_W, divisor SUM_W, quotient OUT_W.
  - Handles the force-zero and saturation cases internally.
- Top level owns the buffer, accumulator, FSM and handshakes.

Test Plan:
- Uniform vector: 8 inputs of {pos=16, mant=0x8000}, out_ready=1 → 8 outputs of 0x2000; out_last only on the 8th; first out_valid 18 cycles after the last accept.
- Ratio vector: e0={16,0x8000}, e1={17,0x8000}, e2..e7 mant=0 → out0=0x5555, out1=0xAAAA, others 0x0000.
- One-hot saturation: e0={20,0xFFFF}, others mant=0 → out0=0xFFFF via 1-cycle forced path, others 0x0000, out_zero_sum=0.
- Zero sum: all mant=0 → 8 outputs of 0x0000 with out_zero_sum=1; next vector proceeds normally.
- Backpressure: uniform vector with out_ready low for 5 cycles on each output → values unchanged while stalled; in_ready stays 0 throughout; 8 outputs total.
- Reset mid-operation: assert rst_n=0 during ITER of element 3 → out_valid=0 immediately (asynchronous); after release, in_ready=1 on the next edge; a new uniform vector yields 0x2000 ×8 with no stale data.
